cpu_clock_controller: RTL and testbench
=======================================

Name: cpu_clock_controller

Overview:
- Generates the CPU working clock (clock_out) from main_clk with a programmable divide ratio.
- Adds run/halt control and debounced single-step control for board debugging.
- Passes main_clk through as mem_clk for the CPU's embedded memories.
- Sits at the top of the computer, in place of the fixed divide-by-2 clock generator, and feeds the CPU and the memory clock tree.

Parameters:
- DIV_W, 8, width of div_ratio.
- DEBOUNCE_CYCLES, 16, consecutive stable main_clk cycles needed to accept a step_key level change. Simulation value; the board build overrides it.
- DEB_W, 16, width of the debounce counter. Must hold DEBOUNCE_CYCLES.

Ports:
- main_clk  in  1  sole clock; all logic on posedge.
- resetn  in  1  asynchronous, active-low reset.
- run_sw  in  1  asynchronous level: 1 = free-run, 0 = halt.
- step_key  in  1  raw pushbutton, active-high, bouncy.
- div_ratio  in  DIV_W  half-period of clock_out in main_clk cycles; 0 is treated as 1.
- clock_out  out  1  CPU clock, registered.
- mem_clk  out  1  equals main_clk, combinational passthrough.
- halted  out  1  1 while the FSM is in HALT.
- cycle_count  out  32  number of clock_out rising edges since reset.

Behaviour:
- Reset (resetn=0, asynchronous): clock_out=0, state=HALT, halted=1, cycle_count=0, phase counter=0, synchronizers=0, debounced level=0, debounce counter=0.
- Input synchronization: run_sw and step_key each pass through a 2-flop synchronizer, giving 2 cycles of latency.
- Debounce:
  - The debounced level copies sync_step only after sync_step has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the current level clears the debounce counter.
  - A step press is a 0->1 transition of the debounced level, a 1-cycle internal pulse.
- Effective ratio N = (div_ratio==0) ? 1 : div_ratio.
  - N is latched into half_reg when leaving HALT and at every clock_out toggle.
  - A ratio change never shortens or stretches the phase in progress.
- Phase counter cnt:
  - Counts 0..half_reg-1 while the state is RUN or STEP.
  - When cnt==half_reg-1 and a toggle is permitted: clock_out inverts and cnt<=0.
  - Held at 0 in HALT.
  - With N=1 this gives a divide-by-2 clock (toggle every main_clk edge).
- Timing: the first rising edge of clock_out occurs on the N-th main_clk edge after the state leaves HALT. High phase = N cycles, low phase = N cycles.
- FSM states and transitions:
  - HALT:
    - sync_run=1 -> RUN.
    - Otherwise, step press -> STEP.
    - Otherwise, stay in HALT.
    - clock_out is held at 0.
  - RUN:
    - While sync_run=1, toggle freely.
    - sync_run=0 while clock_out=0 -> HALT next cycle; cnt cleared; low level holds.
    - sync_run=0 while clock_out=1 -> complete the current high phase; on the falling toggle go to HALT. A halt never truncates a high phase.
  - STEP:
    - Produce exactly one rising toggle, then one falling toggle.
    - On the falling toggle: go to RUN if sync_run=1, else HALT.
- Step presses in RUN or STEP are ignored, not queued.
- A run_sw change during STEP takes effect only at the end of the step.
- cycle_count increments by 1 on each rising toggle of clock_out and wraps 0xFFFFFFFF -> 0.
- halted is registered and equals (state==HALT).
- clock_out has no combinational path from any input: a glitch-free, registered output.
- resetn asserted mid-phase: everything returns immediately to reset values, including clock_out=0.

Test Plan:
- Reset mid-run: assert resetn=0 while clock_out=1 and cycle_count=37 -> same instant: clock_out=0, halted=1, cycle_count=0; stays so until run_sw is resynchronized after release.
- Free-run N=1: run_sw=1, div_ratio=1 -> halted falls 3 edges after run_sw rises (2 synchronizer + 1 FSM); clock_out period 2 main_clk; cycle_count=10 after 10 periods.
- Ratio change: RUN with div_ratio=3; change to 5 two cycles into a high phase -> that high phase lasts 3 cycles; following phases last 5 cycles. div_ratio=0 -> phases of 1 cycle.
- Halt during high: div_ratio=4; drop run_sw 1 cycle after a rising toggle -> high phase still 4 cycles total; falling toggle; halted=1; clock_out stays 0 for 100 cycles; cycle_count frozen.
- Debounced step:
  - In HALT with div_ratio=2, DEBOUNCE_CYCLES=16: bounce step_key with pulses of 3, 5 and 10 cycles -> no clock_out activity.
  - Then hold step_key high for 20 cycles -> exactly one clock_out pulse (2 high, then 2 low); cycle_count +1; halted returns to 1.
  - Holding the key longer produces no further pulses.
- Step and run interaction: press step, then raise run_sw during the STEP high phase -> the step pulse completes normally, then the FSM enters RUN with continuous toggling and halted stays 0. A second press during RUN changes nothing.

Source files
------------

// File: rtl/cpu_clock_controller.sv
// rtl/cpu_clock_controller.sv - programmable CPU clock divider with run/halt and debounced single-step
module cpu_clock_controller #(
    parameter int DIV_W           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DEB_W           = 16
) (
    input  logic             main_clk,
    input  logic             resetn,
    input  logic             run_sw,
    input  logic             step_key,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             clock_out,
    output logic             mem_clk,
    output logic             halted,
    output logic [31:0]      cycle_count
);

    typedef enum logic [1:0] {
        ST_HALT,
        ST_RUN,
        ST_STEP
    } state_t;

    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    state_t             state;
    state_t             next_state;
    logic               run_meta;
    logic               run_sync;
    logic               step_meta;
    logic               step_sync;
    logic               deb_level;
    logic               deb_prev;
    logic [DEB_W-1:0]   deb_cnt;
    logic               step_press;
    logic [DIV_W-1:0]   half_reg;
    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   eff_n;
    logic               at_end;
    logic               toggle;

    assign mem_clk    = main_clk;
    assign eff_n      = (div_ratio == '0) ? ONE : div_ratio;
    assign at_end     = (cnt == half_reg - ONE);
    assign step_press = deb_level & ~deb_prev;

    always_ff @(posedge main_clk or negedge resetn) begin
        if (!resetn) begin
            run_meta  <= 1'b0;
            run_sync  <= 1'b0;
            step_meta <= 1'b0;
            step_sync <= 1'b0;
        end else begin
            run_meta  <= run_sw;
            run_sync  <= run_meta;
            step_meta <= step_key;
            step_sync <= step_meta;
        end
    end

    // Level only follows the key after an unbroken run of differing samples.
    always_ff @(posedge main_clk or negedge resetn) begin
        if (!resetn) begin
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            deb_prev <= deb_level;
            if (step_sync != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level <= step_sync;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_ONE;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_ff @(posedge main_clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_HALT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        toggle     = 1'b0;
        case (state)
            ST_HALT: begin
                if (run_sync) begin
                    next_state = ST_RUN;
                end else if (step_press) begin
                    next_state = ST_STEP;
                end
            end
            ST_RUN: begin
                if (run_sync) begin
                    toggle = at_end;
                end else if (clock_out) begin
                    // A halt request waits for the high phase to finish.
                    toggle = at_end;
                    if (at_end) begin
                        next_state = ST_HALT;
                    end
                end else begin
                    next_state = ST_HALT;
                end
            end
            ST_STEP: begin
                toggle = at_end;
                if (at_end && clock_out) begin
                    next_state = run_sync ? ST_RUN : ST_HALT;
                end
            end
            default: next_state = ST_HALT;
        endcase
    end

    always_ff @(posedge main_clk or negedge resetn) begin
        if (!resetn) begin
            clock_out   <= 1'b0;
            cnt         <= '0;
            half_reg    <= ONE;
            cycle_count <= 32'd0;
            halted      <= 1'b1;
        end else begin
            halted <= (next_state == ST_HALT);
            // Ratio is sampled only at phase boundaries so a change never bends a phase.
            if (state == ST_HALT || toggle) begin
                half_reg <= eff_n;
            end
            if (state == ST_HALT || next_state == ST_HALT || toggle) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
            if (toggle) begin
                clock_out <= ~clock_out;
                if (!clock_out) begin
                    cycle_count <= cycle_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_clock_controller.sv
// tb/tb_cpu_clock_controller.sv - self-checking bench for cpu_clock_controller against a behavioural model
module tb_cpu_clock_controller;

    localparam int DIV_W = 8;
    localparam int DEB   = 16;

    logic             main_clk = 1'b0;
    logic             resetn   = 1'b0;
    logic             run_sw   = 1'b0;
    logic             step_key = 1'b0;
    logic [DIV_W-1:0] div_ratio = 8'd1;
    logic             clock_out;
    logic             mem_clk;
    logic             halted;
    logic [31:0]      cycle_count;

    cpu_clock_controller #(
        .DIV_W(DIV_W),
        .DEBOUNCE_CYCLES(DEB),
        .DEB_W(16)
    ) dut (
        .main_clk(main_clk),
        .resetn(resetn),
        .run_sw(run_sw),
        .step_key(step_key),
        .div_ratio(div_ratio),
        .clock_out(clock_out),
        .mem_clk(mem_clk),
        .halted(halted),
        .cycle_count(cycle_count)
    );

    always #5 main_clk = ~main_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0=halt 1=run 2=step; m_left = cycles remaining in the current phase.
    int          m_mode;
    bit          m_clk;
    int          m_left;
    int unsigned m_count;
    bit          m_halted;
    bit          rq[2];
    bit          sq[2];
    bit          m_level;
    int          m_stable;
    bit          m_press;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_clk = 0; m_left = 0; m_count = 0; m_halted = 1;
        rq[0] = 0; rq[1] = 0; sq[0] = 0; sq[1] = 0;
        m_level = 0; m_stable = 0; m_press = 0;
    endtask

    task automatic model_step();
        bit s_run, s_step, press, tog, rose;
        int n, new_mode;
        if (!resetn) begin
            model_reset();
            return;
        end
        s_run  = rq[1];
        s_step = sq[1];
        press  = m_press;
        n      = (div_ratio == 0) ? 1 : int'(div_ratio);
        tog    = 0;
        new_mode = m_mode;
        case (m_mode)
            0: begin
                if (s_run) begin new_mode = 1; m_left = n; end
                else if (press) begin new_mode = 2; m_left = n; end
            end
            1: begin
                if (s_run || m_clk) begin
                    m_left--;
                    if (m_left == 0) begin
                        tog = 1;
                        m_left = n;
                        if (!s_run) new_mode = 0;
                    end
                end else begin
                    new_mode = 0;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    tog = 1;
                    m_left = n;
                    if (m_clk) new_mode = s_run ? 1 : 0;
                end
            end
        endcase
        if (tog) begin
            m_clk = !m_clk;
            if (m_clk) m_count++;
        end
        m_mode   = new_mode;
        m_halted = (new_mode == 0);
        rose = 0;
        if (s_step != m_level) begin
            m_stable++;
            if (m_stable == DEB) begin
                m_level  = s_step;
                m_stable = 0;
                rose     = m_level;
            end
        end else begin
            m_stable = 0;
        end
        m_press = rose;
        rq[1] = rq[0]; rq[0] = run_sw;
        sq[1] = sq[0]; sq[0] = step_key;
    endtask

    task automatic tick();
        @(posedge main_clk);
        model_step();
        #1;
        check("clock_out", 32'(clock_out), 32'(m_clk));
        check("halted", 32'(halted), 32'(m_halted));
        check("cycle_count", cycle_count, m_count);
        check("mem_clk", 32'(mem_clk), 32'd1);
    endtask

    task automatic wait_level(input logic val, input string tag, output int n);
        n = 0;
        while (clock_out !== val && n < 400) begin
            tick();
            n++;
        end
        check(tag, 32'(clock_out), 32'(val));
    endtask

    int          n;
    int unsigned saved;
    bit          saw_halt;
    int          seg;
    int          bounce[3] = '{3, 5, 10};

    initial begin
        model_reset();
        repeat (3) tick();
        check("reset_clock_out", 32'(clock_out), 32'd0);
        check("reset_halted", 32'(halted), 32'd1);
        check("reset_count", cycle_count, 32'd0);
        resetn = 1'b1;
        repeat (2) tick();

        // Free-run at N=1
        run_sw = 1'b1; div_ratio = 8'd1;
        n = 0;
        do begin tick(); n++; end while (halted && n < 10);
        check("halt_release_edges", 32'(n), 32'd3);
        repeat (20) tick();
        check("count_10_periods", cycle_count, 32'd10);

        // Ratio change mid high phase
        div_ratio = 8'd3;
        wait_level(1'b0, "wait_lo_r3", n);
        wait_level(1'b1, "wait_hi_r3", n);
        wait_level(1'b0, "wait_lo2_r3", n);
        wait_level(1'b1, "wait_hi2_r3", n);
        tick(); tick();
        div_ratio = 8'd5;
        wait_level(1'b0, "hi_end_r3", n);
        check("hi_len_before_change", 32'(n + 2), 32'd3);
        wait_level(1'b1, "lo_end_r5", n);
        check("lo_len_after_change", 32'(n), 32'd5);
        wait_level(1'b0, "hi_end_r5", n);
        check("hi_len_after_change", 32'(n), 32'd5);
        div_ratio = 8'd0;
        wait_level(1'b1, "lo_end_r0", n);
        wait_level(1'b0, "hi_end_r0", n);
        check("hi_len_div0", 32'(n), 32'd1);
        wait_level(1'b1, "lo_end2_r0", n);
        check("lo_len_div0", 32'(n), 32'd1);

        // Halt requested during a high phase
        div_ratio = 8'd4;
        wait_level(1'b0, "pre_halt_lo", n);
        wait_level(1'b1, "pre_halt_hi", n);
        tick();
        run_sw = 1'b0;
        wait_level(1'b0, "halt_fall", n);
        check("hi_len_halt", 32'(n + 1), 32'd4);
        check("halted_after_fall", 32'(halted), 32'd1);
        saved = cycle_count;
        repeat (100) tick();
        check("count_frozen", cycle_count, saved);
        check("clock_low_halted", 32'(clock_out), 32'd0);

        // Debounced single step
        div_ratio = 8'd2;
        saved = cycle_count;
        foreach (bounce[i]) begin
            step_key = 1'b1;
            repeat (bounce[i]) tick();
            step_key = 1'b0;
            repeat (20) tick();
        end
        check("bounce_no_pulse", cycle_count, saved);
        check("bounce_halted", 32'(halted), 32'd1);
        step_key = 1'b1;
        repeat (20) tick();
        step_key = 1'b0;
        repeat (30) tick();
        check("step_one_pulse", cycle_count, saved + 1);
        check("step_back_halted", 32'(halted), 32'd1);
        step_key = 1'b1;
        repeat (80) tick();
        step_key = 1'b0;
        repeat (30) tick();
        check("long_hold_one_pulse", cycle_count, saved + 2);

        // Step then run raised during the step high phase
        div_ratio = 8'd4;
        step_key = 1'b1;
        wait_level(1'b1, "step_rise", n);
        run_sw = 1'b1;
        saw_halt = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (i == 10) step_key = 1'b0;
            if (i == 50) step_key = 1'b1;
            if (i == 90) step_key = 1'b0;
            tick();
            if (halted) saw_halt = 1'b1;
        end
        check("step_to_run_no_halt", 32'(saw_halt), 32'd0);

        // Randomized stimulus against the model
        for (int k = 0; k < 60; k++) begin
            seg = $urandom_range(1, 40);
            step_key = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 2) == 0) div_ratio = 8'($urandom_range(0, 5));
            repeat (seg) tick();
        end
        step_key = 1'b0;

        // Asynchronous reset mid-run at count 37
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        run_sw = 1'b1; div_ratio = 8'd1;
        n = 0;
        while (!(cycle_count == 32'd37 && clock_out) && n < 200) begin
            tick();
            n++;
        end
        check("reached_37", cycle_count, 32'd37);
        #3;
        resetn = 1'b0;
        #1;
        model_reset();
        check("async_clock_out", 32'(clock_out), 32'd0);
        check("async_halted", 32'(halted), 32'd1);
        check("async_count", cycle_count, 32'd0);
        repeat (3) tick();
        resetn = 1'b1;
        n = 0;
        do begin tick(); n++; end while (halted && n < 10);
        check("resync_edges", 32'(n), 32'd3);
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
